tinyalu_cmd_issuer: RTL

Synthesizable command master that sits directly upstream of the TinyALU DUT and drives its `start`/`done` pin protocol from a buffered command stream. Commands arrive on a valid/ready interface, are queued in a small FIFO, and are issued to the ALU one at a time. Each completed arithmetic operation is returned on a valid/ready response interface. This replaces the testbench task-level driver when the ALU is embedded in a larger RTL datapath.

---
 rtl/tiny_alu_pkg.sv | 32 +++
 rtl/tinyalu_cmd_fifo.sv | 47 ++++
 rtl/tinyalu_cmd_issuer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/tiny_alu_pkg.sv
// Shared TinyALU opcode encoding, issuer FSM state type and the queued command format.
package tiny_alu_pkg;

  typedef enum logic [2:0] {
    NO_OP  = 3'b000,
    ADD_OP = 3'b001,
    AND_OP = 3'b010,
    XOR_OP = 3'b011,
    MUL_OP = 3'b100,
    RST_OP = 3'b111
  } operation_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    NOP,
    RST,
    ERR
  } issuer_state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  // Codes 101 and 110 have no ALU meaning and are answered with an error response.
  function automatic logic is_illegal(input logic [2:0] op);
    return (op == 3'b101) || (op == 3'b110);
  endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Synchronous command FIFO; a count register separates full from empty, no push/pop bypass.
module tinyalu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/tinyalu_cmd_issuer.sv
// Buffers commands and drives the TinyALU start/done protocol, returning one response per op.
// Optional ISSUE watchdog is enabled by defining TINYALU_ISSUER_TIMEOUT_EN.
module tinyalu_cmd_issuer
  import tiny_alu_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  output logic        alu_reset_n,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_err
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("tinyalu_cmd_issuer: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  issuer_state_t state;
  cmd_t          push_data;
  cmd_t          head;
  logic          full;
  logic          empty;
  logic          pop;
  logic [2:0]    cur_op;
  logic          rst_cnt;

  // A response consumed this cycle frees the register, so the next pop may happen on the same edge.
  assign pop         = (state == IDLE) && !empty && (!rsp_valid || rsp_ready);
  assign cmd_ready   = !full && !reset;
  assign alu_reset_n = !(reset || (state == RST));
  assign push_data   = '{op: cmd_op, a: cmd_a, b: cmd_b};

  tinyalu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid && cmd_ready),
    .pop   (pop),
    .wdata (push_data),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

`ifdef TINYALU_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;
  logic          abort;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
      cur_op     <= '0;
      rst_cnt    <= 1'b0;
`ifdef TINYALU_ISSUER_TIMEOUT_EN
      to_cnt     <= '0;
      abort      <= 1'b0;
`endif
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            cur_op <= head.op;
            if (is_illegal(head.op)) begin
              state <= ERR;
            end else if (head.op == RST_OP) begin
              state   <= RST;
              rst_cnt <= 1'b0;
            end else begin
              alu_a  <= head.a;
              alu_b  <= head.b;
              alu_op <= head.op;
              if (head.op == NO_OP) begin
                state     <= NOP;
                alu_start <= 1'b1;
              end else begin
                state <= ISSUE;
`ifdef TINYALU_ISSUER_TIMEOUT_EN
                to_cnt <= '0;
`endif
              end
            end
          end
        end
        ISSUE: begin
          // Done only counts once start has actually been presented to the ALU.
          if (alu_start && alu_done) begin
            alu_start  <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_op     <= cur_op;
            rsp_err    <= 1'b0;
            state      <= IDLE;
          end
`ifdef TINYALU_ISSUER_TIMEOUT_EN
          else if (alu_start && to_cnt == TO_LAST) begin
            alu_start <= 1'b0;
            abort     <= 1'b1;
            rst_cnt   <= 1'b0;
            state     <= RST;
          end
`endif
          else begin
            alu_start <= 1'b1;
`ifdef TINYALU_ISSUER_TIMEOUT_EN
            if (alu_start) to_cnt <= to_cnt + 1'b1;
`endif
          end
        end
        NOP: begin
          alu_start <= 1'b0;
          state     <= IDLE;
        end
        RST: begin
          if (rst_cnt) begin
`ifdef TINYALU_ISSUER_TIMEOUT_EN
            state <= abort ? ERR : IDLE;
`else
            state <= IDLE;
`endif
          end else begin
            rst_cnt <= 1'b1;
          end
        end
        ERR: begin
          rsp_valid  <= 1'b1;
          rsp_err    <= 1'b1;
          rsp_result <= '0;
          rsp_op     <= cur_op;
          state      <= IDLE;
`ifdef TINYALU_ISSUER_TIMEOUT_EN
          abort      <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
